// File: rtl/segment_desc_gen.sv
// segment_desc_gen: splits segment instructions into burst descriptors that never
// cross a MAX_BURST boundary, with a one-entry pending slot and play repetition.
module segment_desc_gen #(
  parameter int MAX_BURST = 4096,
  parameter int LW        = 13
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [127:0]  segment_instruc,
  input  logic          segment_instruc_valid,
  input  logic          abort,
  output logic [31:0]   desc_addr,
  output logic [LW-1:0] desc_len,
  output logic          desc_last,
  output logic          desc_valid,
  input  logic          desc_ready,
  output logic          generate_done,
  output logic          desc_gen_last,
  output logic          busy,
  output logic [1:0]    err,
  output logic [1:0]    dbg_state
);
  localparam int OW = $clog2(MAX_BURST);

  // Handshake: a descriptor transfers on a rising edge where desc_valid and
  // desc_ready are both 1; while valid is high and ready low the payload holds.
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ISSUE = 2'd2, FIN = 2'd3} state_t;

  state_t        state_q, state_d;
  logic          pend_v_q, pend_v_d;
  logic [31:0]   pend_addr_q, pend_len_q;
  logic [15:0]   pend_plays_q;
  logic [31:0]   cur_addr_q, remaining_q, seg_addr_q, seg_len_q;
  logic [15:0]   plays_left_q;
  logic          zero_q;
  logic [31:0]   desc_addr_q;
  logic [LW-1:0] desc_len_q;
  logic          desc_last_q, desc_valid_q, gen_done_q, gen_last_q, busy_q;
  logic [1:0]    err_q;

  logic          is_seg, seg_strobe, bad_strobe, pend_take, pend_wr;
  logic          hs, reload, seg_end, n_last, l_last;
  logic [31:0]   in_len, step_addr, step_rem, n_addr, n_rem;
  logic [15:0]   in_rep, n_plays;
  logic [LW-1:0] n_len, l_len;
  logic          unused_bits;

  // Largest legal chunk starting at addr with rem bytes left in the play.
  function automatic logic [LW-1:0] chunk_len(input logic [31:0] addr, input logic [31:0] rem);
    logic [31:0] room;
    room = 32'(MAX_BURST) - {{(32-OW){1'b0}}, addr[OW-1:0]};
    return (rem < room) ? rem[LW-1:0] : room[LW-1:0];
  endfunction

  always_comb begin
    is_seg     = segment_instruc[127:125] == 3'b101;
    seg_strobe = segment_instruc_valid && is_seg;
    bad_strobe = segment_instruc_valid && !is_seg;
    pend_take  = state_q == LOAD;
    pend_wr    = seg_strobe && (!pend_v_q || pend_take);
    pend_v_d   = pend_wr || (pend_v_q && !pend_take);
    in_len     = {segment_instruc[63:36], 4'b0000};
    in_rep     = segment_instruc[15:0];

    hs        = desc_valid_q && desc_ready;
    step_addr = cur_addr_q + 32'(desc_len_q);
    step_rem  = remaining_q - 32'(desc_len_q);
    reload    = (step_rem == 32'd0) && (plays_left_q > 16'd1);
    seg_end   = (step_rem == 32'd0) && !reload;
    n_addr    = reload ? seg_addr_q : step_addr;
    n_rem     = reload ? seg_len_q : step_rem;
    n_plays   = reload ? plays_left_q - 16'd1 : plays_left_q;
    n_len     = chunk_len(n_addr, n_rem);
    n_last    = (32'(n_len) == n_rem) && (n_plays == 16'd1);
    l_len     = chunk_len(pend_addr_q, pend_len_q);
    l_last    = (32'(l_len) == pend_len_q) && (pend_plays_q == 16'd1);

    state_d = state_q;
    case (state_q)
      IDLE:    if (pend_v_d) state_d = LOAD;
      LOAD:    state_d = (pend_len_q == 32'd0) ? FIN : ISSUE;
      ISSUE:   if (hs && seg_end) state_d = FIN;
      FIN:     if (!zero_q) state_d = pend_v_d ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      pend_v_q     <= 1'b0;
      pend_addr_q  <= '0;
      pend_len_q   <= '0;
      pend_plays_q <= '0;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      seg_addr_q   <= '0;
      seg_len_q    <= '0;
      plays_left_q <= '0;
      zero_q       <= 1'b0;
      desc_addr_q  <= '0;
      desc_len_q   <= '0;
      desc_last_q  <= 1'b0;
      desc_valid_q <= 1'b0;
      gen_done_q   <= 1'b0;
      gen_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= '0;
    end else if (abort) begin
      state_q      <= IDLE;
      pend_v_q     <= 1'b0;
      zero_q       <= 1'b0;
      desc_valid_q <= 1'b0;
      desc_last_q  <= 1'b0;
      gen_done_q   <= 1'b0;
      gen_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q    <= state_d;
      pend_v_q   <= pend_v_d;
      busy_q     <= (state_d != IDLE) || pend_v_d;
      gen_done_q <= 1'b0;
      gen_last_q <= 1'b0;
      if (pend_wr) begin
        pend_addr_q  <= segment_instruc[95:64];
        pend_len_q   <= in_len;
        pend_plays_q <= (in_rep == 16'd0) ? 16'd1 : in_rep;
      end
      if (seg_strobe && !pend_wr) err_q[0] <= 1'b1;
      if (bad_strobe) err_q[1] <= 1'b1;
      case (state_q)
        LOAD: begin
          cur_addr_q   <= pend_addr_q;
          remaining_q  <= pend_len_q;
          plays_left_q <= pend_plays_q;
          seg_addr_q   <= pend_addr_q;
          seg_len_q    <= pend_len_q;
          gen_done_q   <= 1'b1;
          if (pend_len_q == 32'd0) begin
            zero_q <= 1'b1;
          end else begin
            desc_valid_q <= 1'b1;
            desc_addr_q  <= pend_addr_q;
            desc_len_q   <= l_len;
            desc_last_q  <= l_last;
          end
        end
        ISSUE: begin
          if (hs) begin
            if (seg_end) begin
              desc_valid_q <= 1'b0;
              desc_last_q  <= 1'b0;
              gen_last_q   <= 1'b1;
            end else begin
              cur_addr_q   <= n_addr;
              remaining_q  <= n_rem;
              plays_left_q <= n_plays;
              desc_addr_q  <= n_addr;
              desc_len_q   <= n_len;
              desc_last_q  <= n_last;
            end
          end
        end
        // A zero-length segment spends one extra FIN cycle so its done pulse
        // lands one cycle after generate_done.
        FIN: begin
          if (zero_q) begin
            zero_q     <= 1'b0;
            gen_last_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign unused_bits   = ^{segment_instruc[124:96], segment_instruc[35:16]};
  assign desc_addr     = desc_addr_q;
  assign desc_len      = desc_len_q;
  assign desc_last     = desc_last_q;
  assign desc_valid    = desc_valid_q;
  assign generate_done = gen_done_q;
  assign desc_gen_last = gen_last_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_segment_desc_gen.sv
// Bench for segment_desc_gen: directed timing cases plus randomized segments
// scored against a queue-based model of the descriptor split rules.
module tb_segment_desc_gen;
  localparam int MAX_BURST = 4096;
  localparam int LW        = 13;
  localparam int W         = 32 + LW + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [127:0]  segment_instruc = '0;
  logic          segment_instruc_valid = 1'b0;
  logic          abort = 1'b0;
  logic          desc_ready = 1'b0;
  logic [31:0]   desc_addr;
  logic [LW-1:0] desc_len;
  logic          desc_last, desc_valid, generate_done, desc_gen_last, busy;
  logic [1:0]    err, dbg_state;

  segment_desc_gen #(.MAX_BURST(MAX_BURST), .LW(LW)) dut (
    .clk(clk), .rstn(rstn),
    .segment_instruc(segment_instruc), .segment_instruc_valid(segment_instruc_valid),
    .abort(abort),
    .desc_addr(desc_addr), .desc_len(desc_len), .desc_last(desc_last),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .generate_done(generate_done), .desc_gen_last(desc_gen_last),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int hs_log[$], gd_log[$], gl_log[$];
  int n_cmp = 0;
  int n_err = 0;
  int vld_cnt = 0;
  int rdy_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: walk each play in MAX_BURST-bounded chunks.
  function automatic void model_push(input logic [31:0] addr, input logic [31:0] len,
                                     input logic [15:0] rep);
    int plays;
    logic [31:0] a, r, room, l;
    plays = (rep == 16'd0) ? 1 : int'(rep);
    for (int p = 0; p < plays; p++) begin
      a = addr;
      r = len;
      while (r != 0) begin
        room = 32'(MAX_BURST) - (a % 32'(MAX_BURST));
        l = (r < room) ? r : room;
        r = r - l;
        exp_q.push_back({a, l[LW-1:0], (r == 0) && (p == plays - 1)});
        a = a + l;
      end
    end
  endfunction

  // ---------------- monitor ----------------
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_pl = '0;
  always @(negedge clk) begin
    logic [W-1:0] act, exp;
    act = {desc_addr, desc_len, desc_last};
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (generate_done) gd_log.push_back(cyc);
      if (desc_gen_last) gl_log.push_back(cyc);
      if (desc_valid) vld_cnt++;
      if (prev_stall && desc_valid) check("hold", act, prev_pl);
      if (desc_valid && desc_ready) begin
        hs_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_desc: got 0x%0h expected none", act);
        end else begin
          exp = exp_q.pop_front();
          check("desc", act, exp);
        end
      end
      prev_stall = desc_valid && !desc_ready;
      prev_pl    = act;
    end
  end

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       desc_ready = 1'b1;
        1:       desc_ready = !desc_ready;
        default: desc_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send_seg(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] len,
                          input logic [15:0] rep, input bit expect_ok, output int s);
    logic [127:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom()};
    w[127:125] = op;
    w[95:64]   = addr;
    w[63:32]   = len;
    w[15:0]    = rep;
    @(posedge clk);
    #1;
    segment_instruc       = w;
    segment_instruc_valid = 1'b1;
    s = cyc;
    if (expect_ok) model_push(addr, len & 32'hFFFF_FFF0, rep);
    @(posedge clk);
    #1;
    segment_instruc_valid = 1'b0;
    segment_instruc       = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic do_abort();
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!busy && !desc_valid) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s_timeout: busy after %0d cycles, required idle", name, budget);
    end
    check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic clear_logs();
    hs_log.delete();
    gd_log.delete();
    gl_log.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s, s2, s3, v0;
    logic [31:0] a, l;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {desc_valid, desc_last, generate_done, desc_gen_last, busy, err}, 0);
    check("rst_payload", {desc_addr, desc_len}, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("post_rst_ctrl", {desc_valid, desc_last, generate_done, desc_gen_last, busy, err}, 0);

    // Two full bursts, cycle-exact timing.
    rdy_mode = 0;
    clear_logs();
    send_seg(3'b101, 32'h1000, 32'h2000, 16'd0, 1, s);
    wait_idle("t1", 50);
    check("t1_hs_count", 64'(hs_log.size()), 2);
    if (hs_log.size() >= 2) begin
      check("t1_first_hs", 64'(hs_log[0]), 64'(s + 2));
      check("t1_second_hs", 64'(hs_log[1]), 64'(s + 3));
    end
    if (gd_log.size() >= 1) check("t1_gen_done", 64'(gd_log[0]), 64'(s + 2));
    if (gl_log.size() >= 1) check("t1_gen_last", 64'(gl_log[0]), 64'(s + 4));

    // Boundary split and 32-bit wrap.
    clear_logs();
    send_seg(3'b101, 32'h0000_0FF0, 32'h40, 16'd0, 1, s);
    wait_idle("t2a", 50);
    check("t2a_hs_count", 64'(hs_log.size()), 2);
    clear_logs();
    send_seg(3'b101, 32'hFFFF_FFF0, 32'h20, 16'd0, 1, s);
    wait_idle("t2b", 50);
    check("t2b_hs_count", 64'(hs_log.size()), 2);

    // Repeat: three plays back to back.
    clear_logs();
    send_seg(3'b101, 32'h100, 32'h20, 16'd3, 1, s);
    wait_idle("t3", 50);
    check("t3_hs_count", 64'(hs_log.size()), 3);
    if (hs_log.size() >= 3) check("t3_no_bubble", 64'(hs_log[2] - hs_log[0]), 2);

    // Backpressure with toggling ready.
    rdy_mode = 1;
    clear_logs();
    send_seg(3'b101, 32'h1000, 32'h2000, 16'd0, 1, s);
    wait_idle("t4", 80);
    check("t4_hs_count", 64'(hs_log.size()), 2);

    // Pending slot, overflow, bad opcode.
    rdy_mode = 0;
    @(posedge clk);
    clear_logs();
    send_seg(3'b101, 32'h0, 32'h4000, 16'd0, 1, s);
    send_seg(3'b101, 32'h8000, 32'h20, 16'd0, 1, s2);
    send_seg(3'b101, 32'h9000, 32'h20, 16'd0, 0, s3);
    wait_idle("t5", 100);
    check("t5_err_overflow", err, 2'b01);
    check("t5_hs_count", 64'(hs_log.size()), 5);
    if (hs_log.size() >= 5 && gl_log.size() >= 1)
      check("t5_pending_issue", 64'(hs_log[4]), 64'(gl_log[0] + 2));
    clear_logs();
    send_seg(3'b111, 32'h100, 32'h40, 16'd0, 0, s);
    repeat (6) @(negedge clk);
    check("t5_err_opcode", err, 2'b11);
    check("t5_bad_no_desc", 64'(hs_log.size() + gd_log.size()), 0);
    do_abort();
    @(negedge clk);
    check("t5_err_cleared", err, 2'b00);

    // Zero length (low length bits are forced to zero).
    clear_logs();
    v0 = vld_cnt;
    send_seg(3'b101, 32'h500, 32'h0000_000F, 16'd2, 1, s);
    wait_idle("t6", 30);
    check("t6_no_valid", 64'(vld_cnt - v0), 0);
    if (gd_log.size() >= 1) check("t6_gen_done", 64'(gd_log[0]), 64'(s + 2));
    else check("t6_gen_done_seen", 64'(gd_log.size()), 1);
    if (gl_log.size() >= 1) check("t6_gen_last", 64'(gl_log[0]), 64'(s + 3));
    else check("t6_gen_last_seen", 64'(gl_log.size()), 1);

    // Abort mid-ISSUE with a pending instruction and a set error.
    send_seg(3'b101, 32'h0, 32'h10000, 16'd0, 1, s);
    send_seg(3'b101, 32'h40000, 32'h100, 16'd0, 1, s2);
    send_seg(3'b101, 32'h50000, 32'h100, 16'd0, 0, s3);
    do_abort();
    @(negedge clk);
    check("t7_abort_outputs", {desc_valid, busy, generate_done, desc_gen_last, err}, 0);
    clear_logs();
    repeat (5) @(negedge clk);
    check("t7_quiet", 64'(hs_log.size() + gd_log.size()), 0);

    // Asynchronous reset mid-segment.
    send_seg(3'b101, 32'h2000, 32'h8000, 16'd2, 1, s);
    repeat (4) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check("t8_async_ctrl", {desc_valid, desc_last, generate_done, desc_gen_last, busy, err}, 0);
    check("t8_async_payload", {desc_addr, desc_len}, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rstn = 1'b1;

    // Randomized segments under random ready patterns.
    for (int i = 0; i < 40; i++) begin
      rdy_mode = $urandom_range(0, 2);
      case ($urandom_range(0, 2))
        0:       a = $urandom() & 32'hFFFF_FFF0;
        1:       a = 32'(MAX_BURST) * 32'($urandom_range(1, 64)) - 32'(16 * $urandom_range(0, 8));
        default: a = 32'd0 - 32'(16 * $urandom_range(1, 16));
      endcase
      l = 32'($urandom_range(0, 3 * MAX_BURST + 40));
      send_seg(3'b101, a, l, 16'($urandom_range(0, 3)), 1, s);
      wait_idle("rand", 600);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/segment_desc_gen.md
# segment_desc_gen

Descriptor generator directly downstream of the instruction fetcher. Consumes one-cycle segment-instruction strobes, splits each segment (base address, byte length, repeat count) into burst descriptors that never cross a MAX_BURST-aligned boundary, and hands them to the waveform DMA over a valid/ready handshake. Reports segment start (`generate_done`) and final-descriptor issue (`desc_gen_last`) back to the fetcher, which uses them to pace prefetch and issue of the next instruction.

## Interface
- MAX_BURST, 4096: max descriptor length in bytes; power of two, ≥16.
- LW, 13: width of `desc_len`, equal to log2(MAX_BURST)+1.
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- segment_instruc  in  128  instruction word: [127:125] opcode (3'b101 = segment); [95:64] seg_addr; [63:32] seg_len bytes, with bits [3:0] forced to 0; [15:0] rep, plays = max(rep,1); all other bits ignored.
- segment_instruc_valid  in  1  one-cycle strobe; no ready.
- abort  in  1  synchronous flush.
- desc_addr  out  32  descriptor byte address.
- desc_len  out  LW  descriptor bytes, 16..MAX_BURST.
- desc_last  out  1  final descriptor of final play.
- desc_valid  out  1  descriptor valid.
- desc_ready  in  1  DMA accept.
- generate_done  out  1  one-cycle pulse: segment loaded.
- desc_gen_last  out  1  one-cycle pulse: segment fully issued.
- busy  out  1  state ≠ IDLE or pending valid.
- err  out  2  sticky; [0] pending overflow, [1] non-segment opcode strobed.

## Operation
- Pending register, one entry. A strobe with opcode 101 writes it and sets pend_v.
  - Strobe while pend_v=1 and pending not consumed that cycle: instruction dropped, err[0] set.
  - Strobe with other opcode: ignored, err[1] set.
- Active registers: cur_addr (32), remaining (32), plays_left (16), plus the reload copies seg_addr and seg_len.
- States:
  - IDLE: pend_v → LOAD.
  - LOAD: copy pending to active and clear pend_v. If a new strobe arrives in the same cycle, it is written and pend_v stays 1. seg_len=0 → FIN, otherwise → ISSUE.
  - ISSUE: desc_valid=1.
    - desc_len = min(remaining, MAX_BURST − (cur_addr mod MAX_BURST)).
    - On handshake: cur_addr += desc_len (mod 2^32); remaining −= desc_len.
    - If remaining reaches 0 and plays_left>1: reload cur_addr and remaining, decrement plays_left, stay in ISSUE.
    - If remaining reaches 0 on the last play: → FIN.
  - FIN: desc_gen_last=1. pend_v → LOAD, otherwise → IDLE.
- desc_last = 1 iff the current descriptor ends the segment's last play.
- Payload is stable while desc_valid=1 and desc_ready=0.
- abort: on the next edge, state=IDLE, pend_v=0, all pulses 0, desc_valid=0, err cleared. abort has priority over every other event, including a simultaneous handshake or strobe.

## Timing
- Reset values: desc_valid, desc_last, generate_done, desc_gen_last, busy = 0; err = 0; desc_addr, desc_len = 0; state = IDLE.
- All outputs are registered.
- Strobe in cycle 0 (IDLE, pending empty): LOAD in cycle 1. In cycle 2, generate_done=1 and, if seg_len≠0, desc_valid=1 with the first descriptor.
- One descriptor per cycle when desc_ready=1, with no bubbles, including across play reloads.
- Final handshake in cycle k: cycle k+1 is FIN with desc_gen_last=1 and desc_valid=0. Cycle k+2 is LOAD (pending) or IDLE.
- Zero-length segment: generate_done in the cycle after LOAD, desc_gen_last one cycle later. No descriptors are emitted.
- Strobe during ISSUE or FIN is held in pending; the first descriptor of the next segment follows the FIN cycle after LOAD.

## Test plan
- addr 0x1000, len 0x2000, rep 0, ready=1 → (0x1000, 4096, last=0), (0x2000, 4096, last=1) on consecutive cycles; generate_done 2 cycles after the strobe; desc_gen_last 1 cycle after the last handshake.
- Boundary split: addr 0x0FF0, len 0x40 → (0x0FF0, 16), (0x1000, 48, last=1). Wrap: addr 0xFFFFFFF0, len 0x20 → (0xFFFFFFF0, 16), (0x00000000, 16, last=1).
- Repeat: addr 0x100, len 0x20, rep 3 → three descriptors (0x100, 32); desc_last only on the third; no idle cycles between them.
- Backpressure: desc_ready toggling 1010…, random payload hold checks → payload stable while stalled; descriptor count and addresses match the ready=1 case.
- Pending and overflow:
  - Strobe B during A's ISSUE → B's first descriptor issues 2 cycles after A's FIN.
  - A third strobe C while B is pending → C dropped, err=2'b01.
  - Opcode 3'b111 strobe → err[1]=1, no descriptors.
- Zero length and abort:
  - len 0 → generate_done, then desc_gen_last the next cycle, no desc_valid.
  - abort mid-ISSUE with pending valid → next cycle desc_valid=0, busy=0, err=0.
  - rstn low mid-segment → all outputs 0 asynchronously.
